// File: rtl/shift_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_counter_pkg
// Description : Shared constants and helpers for the shift-register counter
//               family (Johnson / ring sequence generators).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package shift_counter_pkg;

  // Run-time mode select encoding.
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  // Widest register the start-state helper can describe. Callers truncate the
  // result to their own WIDTH.
  localparam int MAX_WIDTH = 64;

  // First state of the sequence for a given mode: all zeros for Johnson,
  // 0...01 for ring. Bits at or above 'width' are always zero.
  function automatic logic [MAX_WIDTH-1:0] start_state(input logic mode,
                                                        input int   width);
    logic [MAX_WIDTH-1:0] s;
    s = '0;
    if ((mode == MODE_RING) && (width > 0)) begin
      s[0] = 1'b1;
    end
    return s;
  endfunction

endpackage : shift_counter_pkg
`default_nettype wire

// File: rtl/shift_counter_phase_dec.sv
`default_nettype none
// ============================================================================
// Module      : shift_counter_phase_dec
// Description : Combinational legality check and binary phase decode for a
//               Johnson or ring shift-register counter value.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module shift_counter_phase_dec
  import shift_counter_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode_q,
  output logic             legal,
  output logic [PW-1:0]    phase
);

  logic [WIDTH-1:0] w_inv;
  logic             w_lo_run_legal;   // ones run anchored at LSB
  logic             w_hi_run_legal;   // zeros run anchored at LSB
  logic             w_ring_legal;     // exactly one bit set
  logic [PW-1:0]    w_ones;
  logic [PW-1:0]    w_zeros;
  logic [PW-1:0]    w_ring_idx;

  // Shape tests: a value is a run of ones from the LSB exactly when adding one
  // carries all the way through it, leaving no overlap with the original bits.
  always_comb begin
    w_inv          = ~count;
    w_lo_run_legal = ((count & (count + WIDTH'(1))) == '0);
    w_hi_run_legal = ((w_inv & (w_inv + WIDTH'(1))) == '0);
    w_ring_legal   = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
  end

  // Population counts of ones and zeros, plus the position of the highest set
  // bit (the only set bit when the value is one-hot).
  always_comb begin
    w_ones     = '0;
    w_zeros    = '0;
    w_ring_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count[i]) begin
        w_ones     = w_ones + PW'(1);
        w_ring_idx = PW'(i);
      end else begin
        w_zeros    = w_zeros + PW'(1);
      end
    end
  end

  // Select the legality rule and phase formula for the active mode; illegal
  // values always report phase 0.
  always_comb begin
    legal = 1'b0;
    phase = '0;
    if (mode_q == MODE_RING) begin
      legal = w_ring_legal;
      if (w_ring_legal) begin
        phase = w_ring_idx;
      end
    end else if (count[WIDTH-1] == 1'b0) begin
      // First half of the Johnson sequence: ones filling in from the LSB.
      legal = w_lo_run_legal;
      if (w_lo_run_legal) begin
        phase = w_ones;
      end
    end else begin
      // Second half: zeros filling in from the LSB.
      legal = w_hi_run_legal;
      if (w_hi_run_legal) begin
        phase = PW'(WIDTH) + w_zeros;
      end
    end
  end

endmodule : shift_counter_phase_dec
`default_nettype wire

// File: rtl/shift_counter_gen.sv
`default_nettype none
// ============================================================================
// Module      : shift_counter_gen
// Description : Run-time selectable Johnson / ring shift counter with up/down
//               stepping, clear, parallel load, terminal count, phase index
//               and self-correction of illegal states.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             en,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             tc,
  output logic             err
);

  // The shift expressions below need at least two bits.
  if ((WIDTH < 2) || (WIDTH > MAX_WIDTH)) begin : g_width_check
    $error("shift_counter_gen: WIDTH must be in 2..%0d", MAX_WIDTH);
  end

  logic             r_mode_q;
  logic [WIDTH-1:0] r_count;
  logic             r_err;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_err_nxt;
  logic [WIDTH-1:0] w_step_up;
  logic [WIDTH-1:0] w_step_dn;
  logic [WIDTH-1:0] w_start_new;
  logic [WIDTH-1:0] w_start_cur;
  logic             w_legal;
  logic [PW-1:0]    w_phase;
  logic [PW-1:0]    w_last_phase;
  logic             w_at_term;

  shift_counter_phase_dec #(
    .WIDTH (WIDTH)
  ) u_phase_dec (
    .count  (r_count),
    .mode_q (r_mode_q),
    .legal  (w_legal),
    .phase  (w_phase)
  );

  assign w_start_new = WIDTH'(start_state(mode, WIDTH));
  assign w_start_cur = WIDTH'(start_state(r_mode_q, WIDTH));

  // One-position moves: ring rotates, Johnson inverts the bit that wraps.
  always_comb begin
    if (r_mode_q == MODE_RING) begin
      w_step_up = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
      w_step_dn = {r_count[0], r_count[WIDTH-1:1]};
    end else begin
      w_step_up = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
      w_step_dn = {~r_count[0], r_count[WIDTH-1:1]};
    end
  end

  // Next-state priority: mode change, clear, load, recovery, step, hold.
  // Recovery pre-empts stepping so a bad value never propagates further.
  always_comb begin
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
    if (mode != r_mode_q) begin
      w_count_nxt = w_start_new;
    end else if (clear) begin
      w_count_nxt = w_start_cur;
    end else if (load) begin
      w_count_nxt = load_val;
    end else if (!w_legal) begin
      w_count_nxt = w_start_cur;
      w_err_nxt   = 1'b1;
    end else if (en) begin
      w_count_nxt = dir ? w_step_up : w_step_dn;
    end
  end

  // Terminal count flags the cycle whose edge will wrap the sequence; any
  // higher-priority action on that edge suppresses it.
  always_comb begin
    w_last_phase = (r_mode_q == MODE_RING) ? PW'(WIDTH - 1) : PW'(2*WIDTH - 1);
    w_at_term    = dir ? (w_phase == w_last_phase) : (w_phase == '0);
    tc           = en & w_legal & ~clear & ~load & (mode == r_mode_q) & w_at_term;
  end

  // State registers; reset leaves the counter in the Johnson start state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode_q <= MODE_JOHNSON;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_mode_q <= mode;
      r_count  <= w_count_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign count = r_count;
  assign phase = w_phase;
  assign err   = r_err;

endmodule : shift_counter_gen
`default_nettype wire

// File: tb/tb_shift_counter_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_counter_gen
// Description : Self-checking bench for shift_counter_gen: directed scenarios
//               followed by randomized stimulus against a sequence-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_counter_gen;

  localparam int WIDTH = 4;
  localparam int PW    = $clog2(2*WIDTH);

  logic             clk;
  logic             reset;
  logic             mode;
  logic             en;
  logic             dir;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    phase;
  logic             tc;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic             m_mode_q;
  logic [WIDTH-1:0] m_count;
  logic             m_err;

  shift_counter_gen #(
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .en       (en),
    .dir      (dir),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .phase    (phase),
    .tc       (tc),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Number of states in the sequence for a mode.
  function automatic int seq_len(input logic m);
    return m ? WIDTH : 2*WIDTH;
  endfunction

  // Value of the p-th state of the sequence, built arithmetically.
  function automatic logic [WIDTH-1:0] seq_val(input logic m, input int p);
    int v;
    if (m) v = 1 << p;
    else if (p < WIDTH) v = (1 << p) - 1;
    else v = ~((1 << (p - WIDTH)) - 1);
    return WIDTH'(v);
  endfunction

  // Position of a value within the sequence, -1 if it is not in it.
  function automatic int seq_index(input logic m, input logic [WIDTH-1:0] c);
    for (int p = 0; p < seq_len(m); p++) begin
      if (seq_val(m, p) == c) return p;
    end
    return -1;
  endfunction

  // One clock: drive inputs at negedge, check outputs, advance model on posedge.
  task automatic step(input logic m, input logic e, input logic d, input logic c,
                      input logic l, input logic [WIDTH-1:0] lv);
    int   idx;
    int   n;
    logic tc_exp;
    @(negedge clk);
    mode = m; en = e; dir = d; clear = c; load = l; load_val = lv;
    #1;
    idx    = seq_index(m_mode_q, m_count);
    n      = seq_len(m_mode_q);
    tc_exp = e && (idx >= 0) && !c && !l && (m == m_mode_q) &&
             (d ? (idx == n - 1) : (idx == 0));
    check("count", 32'(count), 32'(m_count));
    check("phase", 32'(phase), 32'((idx >= 0) ? idx : 0));
    check("tc",    32'(tc),    32'(tc_exp));
    check("err",   32'(err),   32'(m_err));
    @(posedge clk);
    m_err = 1'b0;
    if (m != m_mode_q) begin
      m_mode_q = m;
      m_count  = seq_val(m, 0);
    end else if (c) begin
      m_count = seq_val(m_mode_q, 0);
    end else if (l) begin
      m_count = lv;
    end else if (idx < 0) begin
      m_count = seq_val(m_mode_q, 0);
      m_err   = 1'b1;
    end else if (e) begin
      m_count = seq_val(m_mode_q, d ? (idx + 1) % n : (idx + n - 1) % n);
    end
    #1;
  endtask

  logic [WIDTH-1:0] j_up   [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [WIDTH-1:0] j_dn   [4] = '{4'b0011, 4'b0001, 4'b0000, 4'b1000};
  logic [WIDTH-1:0] r_up   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic             rm;
    logic             re;
    logic             rd;
    logic             rc;
    logic             rl;
    logic [WIDTH-1:0] rv;

    clk = 1'b0; reset = 1'b0; mode = 1'b0; en = 1'b0; dir = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = '0;
    m_mode_q = 1'b0; m_count = '0; m_err = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_tc",    32'(tc),    32'h0);
    check("rst_err",   32'(err),   32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Johnson up through one full wrap.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("j_up", 32'(count), 32'(j_up[i]));
    end

    // Climb to 0111, then count down across the wrap.
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("j_0111", 32'(count), 32'h7);
    check("j_0111_phase", 32'(phase), 32'h3);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      check("j_dn", 32'(count), 32'(j_dn[i]));
    end

    // Switch to ring mid-sequence, then rotate up through a wrap.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("ring_start", 32'(count), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("r_up", 32'(count), 32'(r_up[i]));
    end

    // Illegal load in Johnson mode, recovery with an error pulse.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("j_restart", 32'(count), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0101);
    check("ld_count", 32'(count), 32'h5);
    check("ld_phase", 32'(phase), 32'h0);
    check("ld_err",   32'(err),   32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("rec_count", 32'(count), 32'h0);
    check("rec_err",   32'(err),   32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("resume_count", 32'(count), 32'h1);
    check("resume_err",   32'(err),   32'h0);

    // Clear beats load; then a legal ring load.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100);
    check("clr_wins", 32'(count), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0100);
    check("rload_count", 32'(count), 32'h4);
    check("rload_phase", 32'(phase), 32'h2);

    // Asynchronous reset mid-cycle from 1110, released with ring mode held.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("pre_rst", 32'(count), 32'hE);
    #1;
    reset = 1'b0;
    mode  = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'h0);
    check("arst_err",   32'(err),   32'h0);
    m_mode_q = 1'b0; m_count = '0; m_err = 1'b0;
    #1;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    check("post_rst", 32'(count), 32'h1);

    // Randomized traffic.
    rm = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 4) rm = ~rm;
      re = ($urandom_range(0, 99) < 75);
      rd = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 99) < 5);
      rl = ($urandom_range(0, 99) < 8);
      rv = WIDTH'($urandom);
      step(rm, re, rd, rc, rl, rv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_shift_counter_gen
`default_nettype wire
